fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Small instruction buffer between the instruction-memory response and the decode stage.
- Decouples fetch from decode stalls.
- Splits the head instruction into MIPS fields: opcode, rs, rt, rd, shamt, funct, imm16 and imm26. imm16 and imm26 feed the immediate extender directly.
- Supports a single-cycle flush for branch/jump redirects.

Parameters:
- DEPTH, 2, number of buffered entries; power of two, minimum 2.
- WORD_W, 32, width of the instruction word and of the next-PC word.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset; synchronous, active-high.
- flush  in  1  discard all buffered entries (redirect).
- in_valid  in  1  fetch presents a valid instruction.
- in_ready  out  1  queue can accept an entry this cycle.
- in_instr  in  WORD_W  fetched instruction.
- in_npc  in  WORD_W  PC+4 of the fetched instruction.
- out_valid  out  1  head entry valid.
- out_ready  in  1  decode consumes the head this cycle.
- out_instr  out  WORD_W  head instruction.
- out_npc  out  WORD_W  head PC+4.
- opcode  out  6  out_instr[31:26].
- rs  out  5  out_instr[25:21].
- rt  out  5  out_instr[20:16].
- rd  out  5  out_instr[15:11].
- shamt  out  5  out_instr[10:6].
- funct  out  6  out_instr[5:0].
- imm16  out  16  out_instr[15:0].
- imm26  out  26  out_instr[25:0].
- count  out  clog2(DEPTH+1)  number of valid entries.

Behaviour:
- Storage: circular buffer of DEPTH {instr, npc} entries with write pointer, read pointer and count. Pointers wrap modulo DEPTH.
- push = in_valid & in_ready.
- pop = out_valid & out_ready.
- in_ready = (count < DEPTH). It is registered-state only, with no combinational path from out_ready.
- out_valid = (count != 0).
- Push: entry written at the write pointer, write pointer increments.
- Pop: read pointer increments.
- Simultaneous push and pop (only possible when 0 < count < DEPTH): both happen, count unchanged.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. one cycle.
- No bypass: when empty, in_valid does not appear on out_valid in the same cycle.
- Empty: out_instr, out_npc and all field outputs are forced to 0; out_valid = 0. The output then decodes as a NOP (sll $0,$0,0).
- Full: in_ready = 0; in_valid is ignored and the producer must hold its data.
- Pop while empty is ignored. Push while full is impossible by construction.
- flush = 1: next state is count = 0 and both pointers = 0.
  - A push in the same cycle is dropped; a pop in the same cycle is irrelevant.
  - in_ready depends only on count, so it can be 1 during flush even though the push is discarded.
  - Fetch must not treat a push in a flush cycle as accepted.
- RST = 1: same effect as flush, with priority over flush, push and pop. Storage contents need not be cleared.
- Reset values after reset: count = 0, out_valid = 0, in_ready = 1, all data/field outputs = 0.
- Reset asserted mid-stream discards all entries on that edge.
- Field outputs are pure slices of out_instr; no sign or zero extension is done here (that belongs to the extender).

Test Plan:
- Reset then idle: RST = 1 for 2 cycles, then RST = 0 -> count = 0, out_valid = 0, in_ready = 1, opcode/imm16/imm26 = 0.
- Single pass-through: push 0x2008FFFF with npc 0x00000004 at edge 1 -> after edge 1, out_valid = 1, opcode = 0x08, rs = 0, rt = 8, imm16 = 0xFFFF, out_npc = 0x4.
  - Pop at edge 2 -> out_valid = 0, outputs 0.
- Fill and backpressure (out_ready = 0): push 0x08000010, then 0x3C01ABCD -> count = 2, in_ready = 0.
  - A third in_valid is not accepted.
  - Head shows imm26 = 0x0000010 until popped.
- Wrap-around with streaming: out_ready = 1, in_valid = 1 for 6 cycles with instr = cycle index -> output sequence 0..5 in order, one per cycle after the first.
  - count stays 1; pointers wrap 3 times.
- Flush with concurrent push: count = 2, then flush = 1 with in_valid = 1 (0xDEADBEEF) -> next cycle count = 0, out_valid = 0.
  - 0xDEADBEEF is never output.
- Reset beats flush and push: count = 1, then RST = 1, flush = 1, in_valid = 1 in the same cycle -> count = 0, out_valid = 0, in_ready = 1.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: circular buffer between imem response and decode,
// with registered head outputs, MIPS field split and single-cycle flush.
module fetch_queue #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned WORD_W = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [WORD_W-1:0]                in_instr,
  input  logic [WORD_W-1:0]                in_npc,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [WORD_W-1:0]                out_instr,
  output logic [WORD_W-1:0]                out_npc,
  output logic [5:0]                       opcode,
  output logic [4:0]                       rs,
  output logic [4:0]                       rt,
  output logic [4:0]                       rd,
  output logic [4:0]                       shamt,
  output logic [5:0]                       funct,
  output logic [15:0]                      imm16,
  output logic [25:0]                      imm26,
  output logic [$clog2(DEPTH+1)-1:0]       count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WORD_W-1:0] instr_mem_q [DEPTH];
  logic [WORD_W-1:0] npc_mem_q   [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_instr_q, out_instr_d;
  logic [WORD_W-1:0] out_npc_q, out_npc_d;

  logic              push;
  logic              pop;
  logic              fwd;
  logic [WORD_W-1:0] head_instr;
  logic [WORD_W-1:0] head_npc;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  // Next pointer/count state, plus the next head so outputs stay registered.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    fwd         = 1'b0;
    head_instr  = '0;
    head_npc    = '0;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    out_instr_d = '0;
    out_npc_d   = '0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    // The entry being written this cycle becomes the head when it lands on rd_ptr_d.
    fwd        = push && (wr_ptr_q == rd_ptr_d);
    head_instr = fwd ? in_instr : instr_mem_q[rd_ptr_d];
    head_npc   = fwd ? in_npc   : npc_mem_q[rd_ptr_d];

    in_ready_d  = (count_d < CNT_W'(DEPTH));
    out_valid_d = (count_d != '0);
    out_instr_d = out_valid_d ? head_instr : '0;
    out_npc_d   = out_valid_d ? head_npc   : '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_npc_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_npc_q   <= out_npc_d;
    end
  end

  // Storage is not reset; validity is tracked by count.
  always_ff @(posedge CLK) begin
    if (push && !flush && !RST) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      npc_mem_q[wr_ptr_q]   <= in_npc;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_npc   = out_npc_q;
  assign count     = count_q;

  assign opcode = out_instr_q[31:26];
  assign rs     = out_instr_q[25:21];
  assign rt     = out_instr_q[20:16];
  assign rd     = out_instr_q[15:11];
  assign shamt  = out_instr_q[10:6];
  assign funct  = out_instr_q[5:0];
  assign imm16  = out_instr_q[15:0];
  assign imm26  = out_instr_q[25:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model tracks accepted entries and
// every cycle the DUT head, count and handshakes are compared against it.
module tb_fetch_queue;

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } entry_t;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WORD_W-1:0] in_instr = '0;
  logic [WORD_W-1:0] in_npc = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WORD_W-1:0] out_instr;
  logic [WORD_W-1:0] out_npc;
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd, shamt;
  logic [5:0]        funct;
  logic [15:0]       imm16;
  logic [25:0]       imm26;
  logic [CNT_W-1:0]  count;

  entry_t      sb[$];
  logic [31:0] dut_out[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  fetch_queue #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
    .CLK(CLK), .RST(RST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_npc(in_npc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_npc(out_npc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm16(imm16), .imm26(imm26), .count(count)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference model: entries accepted/consumed on each rising edge.
  always @(posedge CLK) begin
    if (RST || flush) begin
      sb.delete();
    end else begin
      automatic bit acc = in_valid && (sb.size() < DEPTH);
      if (out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back('{instr: in_instr, npc: in_npc});
    end
  end

  task automatic compare_state();
    check("count", 32'(count), 32'(sb.size()));
    check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    check("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
    check("never_deadbeef", 32'(out_instr == 32'hDEADBEEF), 32'd0);
    if (sb.size() != 0) begin
      check("out_instr", out_instr, sb[0].instr);
      check("out_npc", out_npc, sb[0].npc);
      check("rs", 32'(rs), 32'(sb[0].instr[25:21]));
      check("funct", 32'(funct), 32'(sb[0].instr[5:0]));
    end else begin
      check("empty_instr", out_instr, 32'd0);
      check("empty_npc", out_npc, 32'd0);
      check("empty_imm26", 32'(imm26), 32'd0);
    end
  endtask

  // Compare last edge's result, then drive inputs for the next edge.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [31:0] ins, input logic [31:0] npc, input logic ordy);
    @(negedge CLK);
    compare_state();
    RST = r; flush = f; in_valid = v; in_instr = ins; in_npc = npc; out_ready = ordy;
    if (out_valid && out_ready) dut_out.push_back(out_instr);
  endtask

  initial begin
    // Reset then idle
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_imm16", 32'(imm16), 32'd0);

    // Single pass-through
    cyc(0, 0, 1, 32'h2008FFFF, 32'h4, 0);
    @(posedge CLK); #1;
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_opcode", 32'(opcode), 32'h08);
    check("pt_rs", 32'(rs), 32'd0);
    check("pt_rt", 32'(rt), 32'd8);
    check("pt_imm16", 32'(imm16), 32'hFFFF);
    check("pt_npc", out_npc, 32'h4);
    cyc(0, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check("pt_pop_valid", 32'(out_valid), 32'd0);
    check("pt_pop_instr", out_instr, 32'd0);

    // Fill and backpressure
    cyc(0, 0, 1, 32'h08000010, 32'h4, 0);
    cyc(0, 0, 1, 32'h3C01ABCD, 32'h8, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 32'h11111111, 32'hC, 0);
    @(posedge CLK); #1;
    check("full_count", 32'(count), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_imm26", 32'(imm26), 32'h0000010);
    dut_out.delete();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check("drain_n", 32'(dut_out.size()), 32'd2);
    if (dut_out.size() == 2) begin
      check("drain_0", dut_out[0], 32'h08000010);
      check("drain_1", dut_out[1], 32'h3C01ABCD);
    end

    // Wrap-around streaming
    dut_out.delete();
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 32'(i), 32'(4 * i + 4), 1);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 1);
    check("stream_n", 32'(dut_out.size()), 32'd6);
    for (int i = 0; i < dut_out.size() && i < 6; i++) check("stream_seq", dut_out[i], 32'(i));

    // Flush with concurrent push
    cyc(0, 0, 1, 32'hAAAA0001, 32'h10, 0);
    cyc(0, 0, 1, 32'hAAAA0002, 32'h14, 0);
    cyc(0, 1, 1, 32'hDEADBEEF, 32'h18, 0);
    @(posedge CLK); #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0, 1);

    // Reset beats flush and push
    cyc(0, 0, 1, 32'h24420001, 32'h20, 0);
    cyc(1, 1, 1, 32'h12345678, 32'h24, 1);
    @(posedge CLK); #1;
    check("rstpri_count", 32'(count), 32'd0);
    check("rstpri_valid", 32'(out_valid), 32'd0);
    check("rstpri_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
